// File: rtl/logic_unit_arbiter_if.sv
// ----------------------------------------------------------------------------
// logic_unit_arbiter_if
// Handshake and data bundle for the shared logical-unit arbiter.
//   req0_* / req1_* : requester side (valid/ready, op, operands a/b)
//   resp_*          : result side (valid/ready, requester tag, result)
//   busy            : result is held because the consumer is stalling
// Modports:
//   slave  - the arbiter (consumes requests, produces results)
//   master - the surroundings (issue logic and writeback consumer)
// ----------------------------------------------------------------------------
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result, busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// ----------------------------------------------------------------------------
// logic_unit_arbiter
// Shares one WIDTH-bit logical unit (AND/OR/XOR/XNOR) between two requesters
// with round-robin arbitration and a single registered result slot that can
// be refilled in the same cycle it is drained (one op per cycle, no bubble).
//
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   bus         - logic_unit_arbiter_if.slave (requests, result, busy)
//   grant_cnt0  - (LOGIC_ARB_STATS_EN only) saturating accept count, req 0
//   grant_cnt1  - (LOGIC_ARB_STATS_EN only) saturating accept count, req 1
//
// Optional feature macro: LOGIC_ARB_STATS_EN adds the two 16-bit counters.
// NREQ is fixed at 2; any other value is rejected at elaboration.
// ----------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    logic_unit_arbiter_if.slave     bus
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [15:0]             grant_cnt0,
    output logic [15:0]             grant_cnt1
`endif
);

    if (NREQ != 2) begin : g_nreq_check
        $error("logic_unit_arbiter supports NREQ == 2 only");
    end

    typedef enum logic {
        IDLE = 1'b0,   // result register empty
        HOLD = 1'b1    // result register full
    } state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             grant;
    logic             can_accept;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] op_res;

    // Round-robin pick: a lone requester always wins; on a tie the one that
    // did not win last time goes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // The slot can take a new op when empty, or when full but being drained
    // this very cycle. Readies are forced low while reset is asserted.
    assign can_accept     = (state == IDLE) || bus.resp_ready;
    assign bus.req0_ready = rst_n && can_accept && !grant;
    assign bus.req1_ready = rst_n && can_accept &&  grant;
    assign accept         = (bus.req0_valid && bus.req0_ready) ||
                            (bus.req1_valid && bus.req1_ready);

    // Operand mux and the logical unit itself (pure bitwise, no carries).
    always_comb begin
        sel_op = grant ? bus.req1_op : bus.req0_op;
        sel_a  = grant ? bus.req1_a  : bus.req0_a;
        sel_b  = grant ? bus.req1_b  : bus.req0_b;
        unique case (sel_op)
            2'b00:   op_res = sel_a & sel_b;
            2'b01:   op_res = sel_a | sel_b;
            2'b10:   op_res = sel_a ^ sel_b;
            default: op_res = ~(sel_a ^ sel_b);
        endcase
    end

    // Next state: any accept fills (or refills) the slot; a drain without a
    // refill empties it.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = HOLD;
        end else if (state == HOLD && bus.resp_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the result register is reset too, so a discarded result
            // never leaks out as stale data after reset.
            state           <= IDLE;
            last_grant      <= 1'b1;
            bus.resp_id     <= 1'b0;
            bus.resp_result <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            state <= state_nxt;
            if (accept) begin
                bus.resp_result <= op_res;
                bus.resp_id     <= grant;
                last_grant      <= grant;
            end
        end
    end

    assign bus.resp_valid = (state == HOLD);
    assign bus.busy       = (state == HOLD) && !bus.resp_ready;

`ifdef LOGIC_ARB_STATS_EN
    // Per-requester accept counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!grant && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if ( grant && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// ----------------------------------------------------------------------------
// tb_logic_unit_arbiter
// Directed-vector bench for logic_unit_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
// Define LOGIC_ARB_STATS_EN to also exercise the accept counters.
// ----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

    localparam int WIDTH = 64;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_op    = 2'b00;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 2'b00;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        bus.resp_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        // Reset state
        check("rst_valid",  bus.resp_valid,  1'b0);
        check("rst_id",     bus.resp_id,     1'b0);
        check("rst_result", bus.resp_result, 64'h0);
        check("rst_busy",   bus.busy,        1'b0);
        check("rst_ready0", bus.req0_ready,  1'b0);
        check("rst_ready1", bus.req1_ready,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: req0 alone, XOR of complementary patterns
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b10;
        bus.req0_a     = 64'hAAAAAAAAAAAAAAAA;
        bus.req0_b     = 64'h5555555555555555;
        #1;
        check("t1_ready0", bus.req0_ready, 1'b1);
        check("t1_ready1", bus.req1_ready, 1'b0);
        @(negedge clk);
        idle_inputs();
        check("t1_valid",  bus.resp_valid,  1'b1);
        check("t1_id",     bus.resp_id,     1'b0);
        check("t1_result", bus.resp_result, 64'hFFFFFFFFFFFFFFFF);
        @(negedge clk);
        check("t1_drain",  bus.resp_valid,  1'b0);
        check("t1_keep",   bus.resp_result, 64'hFFFFFFFFFFFFFFFF);

        // 2: tie from reset, req0 first then req1 without a bubble
        reset_pulse();
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b00;
        bus.req0_a     = 64'hAAAAAAAAAAAAAAAA;
        bus.req0_b     = 64'hAAAAAAAAAAAAAAAA;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b11;
        bus.req1_a     = 64'hAAAAAAAAAAAAAAAA;
        bus.req1_b     = 64'hAAAAAAAAAAAAAAAA;
        #1;
        check("t2_ready0", bus.req0_ready, 1'b1);
        check("t2_ready1", bus.req1_ready, 1'b0);
        @(negedge clk);
        check("t2_id0",     bus.resp_id,     1'b0);
        check("t2_result0", bus.resp_result, 64'hAAAAAAAAAAAAAAAA);
        check("t2_rdy1",    bus.req1_ready,  1'b1);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("t2_valid1",  bus.resp_valid,  1'b1);
        check("t2_id1",     bus.resp_id,     1'b1);
        check("t2_result1", bus.resp_result, 64'hFFFFFFFFFFFFFFFF);
        idle_inputs();
        @(negedge clk);
        check("t2_drain",   bus.resp_valid,  1'b0);

        // 3: both valid six cycles, alternating grants, result stays valid
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b01;
        bus.req0_a     = 64'h0F0F0F0F0F0F0F0F;
        bus.req0_b     = 64'hF0F0F0F0F0F0F0F0;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b00;
        bus.req1_a     = 64'h0F0F0F0F0F0F0F0F;
        bus.req1_b     = 64'hF0F0F0F0F0F0F0F0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t3_valid%0d", i), bus.resp_valid, 1'b1);
            check($sformatf("t3_id%0d", i),    bus.resp_id,    (i % 2 == 1) ? 1'b1 : 1'b0);
            check($sformatf("t3_res%0d", i),   bus.resp_result,
                  (i % 2 == 1) ? 64'h0 : 64'hFFFFFFFFFFFFFFFF);
        end
        idle_inputs();
        @(negedge clk);
        check("t3_drain", bus.resp_valid, 1'b0);

        // 4: consumer stall with req1 waiting
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b10;
        bus.req0_a     = 64'h0123456789ABCDEF;
        bus.req0_b     = 64'h0;
        @(negedge clk);
        check("t4_valid", bus.resp_valid,  1'b1);
        check("t4_res",   bus.resp_result, 64'h0123456789ABCDEF);
        idle_inputs();
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b00;
        bus.req1_a     = 64'hFFFFFFFFFFFFFFFF;
        bus.req1_b     = 64'h00FF00FF00FF00FF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t4_busy%0d", i),   bus.busy,        1'b1);
            check($sformatf("t4_rdy1_%0d", i),  bus.req1_ready,  1'b0);
            check($sformatf("t4_stable%0d", i), bus.resp_result, 64'h0123456789ABCDEF);
            check($sformatf("t4_sid%0d", i),    bus.resp_id,     1'b0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        #1;
        check("t4_rdy1_go", bus.req1_ready, 1'b1);
        check("t4_busy_go", bus.busy,       1'b0);
        @(negedge clk);
        check("t4_valid1", bus.resp_valid,  1'b1);
        check("t4_id1",    bus.resp_id,     1'b1);
        check("t4_res1",   bus.resp_result, 64'h00FF00FF00FF00FF);
        idle_inputs();
        @(negedge clk);
        check("t4_drain",  bus.resp_valid,  1'b0);

        // 5: reset while holding a result, then a tie goes to req0
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b01;
        bus.req0_a     = 64'h1;
        bus.req0_b     = 64'h2;
        @(negedge clk);
        check("t5_hold", bus.resp_valid, 1'b1);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid",  bus.resp_valid,  1'b0);
        check("t5_rst_result", bus.resp_result, 64'h0);
        check("t5_rst_busy",   bus.busy,        1'b0);
        bus.resp_ready = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_op    = 2'b00;
        bus.req0_a     = 64'hF0F0F0F0F0F0F0F0;
        bus.req0_b     = 64'hFF00FF00FF00FF00;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 2'b11;
        bus.req1_a     = 64'h0;
        bus.req1_b     = 64'h0;
        #1;
        check("t5_rst_rdy0", bus.req0_ready, 1'b0);
        check("t5_rst_rdy1", bus.req1_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_rdy0", bus.req0_ready, 1'b1);
        check("t5_rdy1", bus.req1_ready, 1'b0);
        @(negedge clk);
        check("t5_id0",  bus.resp_id,     1'b0);
        check("t5_res0", bus.resp_result, 64'hF000F000F000F000);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("t5_id1",  bus.resp_id,     1'b1);
        check("t5_res1", bus.resp_result, 64'hFFFFFFFFFFFFFFFF);
        idle_inputs();
        @(negedge clk);
        check("t5_drain", bus.resp_valid, 1'b0);

`ifdef LOGIC_ARB_STATS_EN
        // 6: accept counters, 5 for req0 then 3 for req1
        reset_pulse();
        check("t6_cnt0_rst", grant_cnt0, 16'd0);
        check("t6_cnt1_rst", grant_cnt1, 16'd0);
        bus.req0_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("t6_cnt0", grant_cnt0, 16'd5);
        check("t6_cnt1", grant_cnt1, 16'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 64-bit logical unit (AND/OR/XOR/XNOR) between two requesters, e.g. the integer issue slot and the address/flag-generation path.
- Round-robin arbitration, valid/ready handshakes on both sides, registered result with requester tag.
- Sits between the issue logic and the ALU writeback mux.
- Sustains one operation per cycle when the consumer does not stall.

Parameters:
- WIDTH, 64, operand and result width in bits.
- NREQ, 2, number of requesters; fixed at 2, other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  00 AND, 01 OR, 10 XOR, 11 XNOR.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  requester that issued the result.
- resp_result  out  WIDTH  logical result.
- busy  out  1  resp_valid held while resp_ready is low (stall indicator).

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: state=IDLE, resp_valid=0, resp_id=0, resp_result=0, busy=0, last_grant=1 (requester 0 wins the first tie). Ready outputs are combinational and 0 during reset.
- FSM states:
  - IDLE: result register empty.
  - HOLD: result register full.
- can_accept = (state==IDLE) | (state==HOLD & resp_ready).
- Grant selection (combinational):
  - One valid requester: that requester.
  - Both valid: the requester that is not last_grant.
  - reqN_ready = can_accept & grant==N. At most one ready is high per cycle.
- Accept = reqN_valid & reqN_ready. On the next edge:
  - resp_result <= op(a,b) of the granted requester.
  - resp_id <= N.
  - last_grant <= N.
  - state <= HOLD.
  - Latency: 1 cycle from accept to resp_valid.
- In HOLD with resp_ready=1 and no new accept: state <= IDLE, resp_valid <= 0. resp_result and resp_id keep their last values.
- In HOLD with resp_ready=1 and a new accept in the same cycle: stay in HOLD and load the new result (back-to-back, no bubble).
- In HOLD with resp_ready=0: resp_result and resp_id are stable; no request is accepted; busy=1.
- resp_valid = (state==HOLD).
- Operand and op inputs are sampled only on accept and may change freely otherwise.
- Ops are bitwise over the full WIDTH with no carries: AND a&b, OR a|b, XOR a^b, XNOR ~(a^b).
- Reset mid-operation: any held result is discarded at once, resp_valid drops asynchronously, last_grant returns to 1.

Optional Feature:
- Macro: LOGIC_ARB_STATS_EN.
- With the macro defined:
  - Two extra output ports, grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counter increments on every accept for its requester.
  - Counters saturate at 16'hFFFF, no wrap.
  - Reset to 0 by rst_n.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Req0 alone, op=10, a=64'hAAAAAAAAAAAAAAAA, b=64'h5555555555555555, resp_ready=1 -> next cycle resp_valid=1, resp_id=0, resp_result=64'hFFFFFFFFFFFFFFFF; the cycle after, resp_valid=0.
2. Both valid from reset, req0 op=00 a=b=64'hAAAAAAAAAAAAAAAA, req1 op=11 a=b=64'hAAAAAAAAAAAAAAAA -> req0 granted first (result 64'hAAAAAAAAAAAAAAAA, id 0), then req1 next cycle (result 64'hFFFFFFFFFFFFFFFF, id 1), no bubble.
3. Both valid for 6 cycles, resp_ready=1 -> grants alternate 0,1,0,1,0,1; resp_valid stays high throughout.
4. Result held with resp_ready=0 for 3 cycles, req1 valid -> busy=1, req1_ready=0, resp_result stable. resp_ready goes high -> req1 accepted the same cycle, its result appears on the next cycle.
5. rst_n pulsed low while in HOLD -> resp_valid=0 immediately. After release, a tie grants req0 first.
6. With LOGIC_ARB_STATS_EN, 5 accepts for req0 and 3 for req1 -> grant_cnt0=5, grant_cnt1=3. Counter preset near 16'hFFFF -> holds at 16'hFFFF.
